upower_hazard_ctrl: RTL and testbench

// Pipeline controller for the 5-stage uPower core (IF/ID/EX/MEM/WB). Keeps its own scoreboard of
// in-flight destination registers and drives PC/IF-ID write enables, ID/EX bubble, IF/ID flush and
// EX operand-forwarding selects. Handles load-use interlock, taken-bc flush, data-memory wait freeze
// and a post-reset hold. Sits beside the pipeline top; the datapath only consumes its outputs.

---
 rtl/upower_pkg.sv | 58 +++++
 rtl/upower_hazard_decode.sv | 53 +++++
 rtl/upower_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_upower_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/upower_pkg.sv
// Shared opcodes, state/forwarding encodings and scoreboard types for the
// uPower pipeline hazard controller.
package upower_pkg;

   localparam logic [5:0] OP_XO  = 6'd31;
   localparam logic [9:0] XO_ADD = 10'd266;
   localparam logic [5:0] OP_LD  = 6'd58;
   localparam logic [5:0] OP_STD = 6'd62;
   localparam logic [5:0] OP_BC  = 6'd19;

   typedef enum logic [1:0] {
      ST_INIT   = 2'b00,
      ST_RUN    = 2'b01,
      ST_FREEZE = 2'b10
   } ctrl_state_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic       use_a;
      logic [4:0] src_a;
      logic       use_b;
      logic [4:0] src_b;
      logic       has_dest;
      logic [4:0] dest;
      logic       is_load;
      logic       is_bc;
   } dec_t;

   typedef struct packed {
      logic       valid;
      logic       is_load;
      logic       has_dest;
      logic [4:0] dest;
   } sb_entry_t;

   typedef struct packed {
      sb_entry_t  e;
      logic       use_a;
      logic [4:0] src_a;
      logic       use_b;
      logic [4:0] src_b;
   } sb_ex_t;

   // MEM/EX result wins over MEM/WB; a load in MEM has no data yet.
   function automatic fwd_sel_e fwd_pick(input sb_entry_t mem, input sb_entry_t wb,
                                         input logic use_src, input logic [4:0] src);
      if (!use_src) return FWD_RF;
      if (mem.valid && mem.has_dest && !mem.is_load && (mem.dest == src)) return FWD_MEM;
      if (wb.valid && wb.has_dest && (wb.dest == src)) return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/upower_hazard_decode.sv
// Combinational register-usage decode of the instruction in the IF/ID latch.
module upower_hazard_decode
   import upower_pkg::*;
(
   input  logic [31:0] instr_i,
   input  logic        valid_i,
   output dec_t        dec_o
);

   logic instr_unused;
   assign instr_unused = instr_i[0];

   // Source/destination fields by opcode; unknown opcodes touch no registers.
   always_comb begin
      dec_o = '0;
      if (valid_i) begin
         case (instr_i[31:26])
            OP_XO: begin
               if (instr_i[10:1] == XO_ADD) begin
                  dec_o.use_a    = 1'b1;
                  dec_o.src_a    = instr_i[25:21];
                  dec_o.use_b    = 1'b1;
                  dec_o.src_b    = instr_i[20:16];
                  dec_o.has_dest = 1'b1;
                  dec_o.dest     = instr_i[15:11];
               end
            end
            OP_LD: begin
               dec_o.use_a    = 1'b1;
               dec_o.src_a    = instr_i[25:21];
               dec_o.has_dest = 1'b1;
               dec_o.dest     = instr_i[20:16];
               dec_o.is_load  = 1'b1;
            end
            OP_STD: begin
               dec_o.use_a = 1'b1;
               dec_o.src_a = instr_i[25:21];
               dec_o.use_b = 1'b1;
               dec_o.src_b = instr_i[20:16];
            end
            OP_BC: begin
               dec_o.use_a = 1'b1;
               dec_o.src_a = instr_i[25:21];
               dec_o.use_b = 1'b1;
               dec_o.src_b = instr_i[20:16];
               dec_o.is_bc = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/upower_hazard_ctrl.sv
// Pipeline hazard controller: private EX/MEM/WB scoreboard, load-use interlock,
// taken-branch flush, memory-wait freeze, post-reset hold and EX forwarding.
module upower_hazard_ctrl
   import upower_pkg::*;
#(
   parameter int unsigned RESET_HOLD = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      id_instr,
   input  logic             id_valid,
   input  logic             ex_branch_taken,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   dec_t id_dec;

   upower_hazard_decode u_decode (
      .instr_i (id_instr),
      .valid_i (id_valid),
      .dec_o   (id_dec)
   );

   // Branch-ness is resolved by the datapath; only register usage matters here.
   logic dec_unused;
   assign dec_unused = id_dec.is_bc;

   ctrl_state_e      state_q, state_d;
   logic [3:0]       hold_q, hold_d;
   sb_ex_t           ex_q, ex_d;
   sb_entry_t        mem_q, mem_d, wb_q, wb_d;
   logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
   logic             frozen, load_use, stall_inc, flush_inc;

   // Hazard detection against the load currently in EX.
   always_comb begin
      frozen   = (state_q != ST_INIT) && !mem_ready;
      load_use = ex_q.e.valid && ex_q.e.is_load && ex_q.e.has_dest &&
                 ((id_dec.use_a && (id_dec.src_a == ex_q.e.dest)) ||
                  (id_dec.use_b && (id_dec.src_b == ex_q.e.dest)));
   end

   // Next state and flow-control outputs; FREEZE with mem_ready back behaves as RUN.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      case (state_q)
         ST_INIT: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (hold_q != 4'd0) hold_d = hold_q - 4'd1;
            if (hold_q <= 4'd1) state_d = ST_RUN;
         end
         default: begin
            if (!mem_ready) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               stall_inc  = 1'b1;
               state_d    = ST_FREEZE;
            end else begin
               state_d = ST_RUN;
               if (ex_branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  flush_inc   = 1'b1;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  stall_inc   = 1'b1;
               end
            end
         end
      endcase
   end

   // Scoreboard shift and saturating counters.
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!frozen) begin
         wb_d  = mem_q;
         mem_d = ex_q.e;
         ex_d  = '0;
         if (!idex_bubble) begin
            ex_d.e.valid    = id_valid;
            ex_d.e.is_load  = id_dec.is_load;
            ex_d.e.has_dest = id_dec.has_dest;
            ex_d.e.dest     = id_dec.dest;
            ex_d.use_a      = id_dec.use_a;
            ex_d.src_a      = id_dec.src_a;
            ex_d.use_b      = id_dec.use_b;
            ex_d.src_b      = id_dec.src_b;
         end
      end
      stall_d = (stall_inc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
      flush_d = (flush_inc && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         hold_q  <= 4'(RESET_HOLD);
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   // Forwarding selects for the instruction in EX.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (ex_q.e.valid) begin
         fwd_a = fwd_pick(mem_q, wb_q, ex_q.use_a, ex_q.src_a);
         fwd_b = fwd_pick(mem_q, wb_q, ex_q.use_b, ex_q.src_b);
      end
   end

   assign ctrl_state   = state_q;
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: tb/tb_upower_hazard_ctrl.sv
// Directed bench for upower_hazard_ctrl; a second instance with 2-bit counters
// shares the stimulus to exercise counter saturation.
module tb_upower_hazard_ctrl;

   localparam logic [31:0] I_ADD1 = 32'h7C432214; // add R4,R2,R3
   localparam logic [31:0] I_ADD2 = 32'h7C843214; // add R6,R4,R4
   localparam logic [31:0] I_ADD7 = 32'h7D093A14; // add R7,R8,R9
   localparam logic [31:0] I_LD   = 32'hE8450002; // ld  R5,2(R2)
   localparam logic [31:0] I_STD  = 32'hF8A20002; // std R2,2(R5)
   localparam logic [31:0] I_BC   = 32'h4C430002; // bc  R2,R3,2
   localparam logic [31:0] I_BC44 = 32'h4C840002; // bc  R4,R4,2

   logic        clk, reset;
   logic [31:0] id_instr;
   logic        id_valid, ex_branch_taken, mem_ready;

   logic        pc_write, ifid_write, ifid_flush, idex_bubble;
   logic [1:0]  fwd_a, fwd_b, ctrl_state;
   logic [15:0] stall_cycles, flush_count;

   logic        pc_write2, ifid_write2, ifid_flush2, idex_bubble2;
   logic [1:0]  fwd_a2, fwd_b2, ctrl_state2;
   logic [1:0]  stall_cycles2, flush_count2;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   upower_hazard_ctrl #(.RESET_HOLD(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
      .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   upower_hazard_ctrl #(.RESET_HOLD(2), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
      .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
      .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
      .idex_bubble(idex_bubble2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
      .ctrl_state(ctrl_state2), .stall_cycles(stall_cycles2), .flush_count(flush_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_flow(input string tag, input logic pc, input logic ifw,
                             input logic fl, input logic bub);
      check_val({tag, ".pc_write"},    32'(pc_write),    32'(pc));
      check_val({tag, ".ifid_write"},  32'(ifid_write),  32'(ifw));
      check_val({tag, ".ifid_flush"},  32'(ifid_flush),  32'(fl));
      check_val({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
   endtask

   task automatic check_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
      check_val({tag, ".fwd_a"}, 32'(fwd_a), 32'(a));
      check_val({tag, ".fwd_b"}, 32'(fwd_b), 32'(b));
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic tk, input logic rdy);
      id_valid        = v;
      id_instr        = ins;
      ex_branch_taken = tk;
      mem_ready       = rdy;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      tick;
      tick;
      reset = 1'b0;

      // cycle 0/1: post-reset hold
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check_val("c0.state", 32'(ctrl_state), 32'h0);
      check_flow("c0", 1'b0, 1'b0, 1'b0, 1'b1);
      check_fwd("c0", 2'b00, 2'b00);
      check_val("c0.stall", 32'(stall_cycles), 32'd0);
      check_val("c0.flush", 32'(flush_count), 32'd0);
      tick;
      check_val("c1.state", 32'(ctrl_state), 32'h0);
      check_val("c1.pc_write", 32'(pc_write), 32'h0);
      tick;

      // cycle 2: RUN; add R4 enters ID
      drive(1'b1, I_ADD1, 1'b0, 1'b1);
      check_val("c2.state", 32'(ctrl_state), 32'h1);
      check_flow("c2", 1'b1, 1'b1, 1'b0, 1'b0);
      tick;
      drive(1'b1, I_ADD2, 1'b0, 1'b1);
      check_fwd("c3", 2'b00, 2'b00);
      check_flow("c3", 1'b1, 1'b1, 1'b0, 1'b0);
      tick;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check_fwd("c4.back2back", 2'b10, 2'b10);
      tick;

      // add, unrelated add, dependent add
      drive(1'b1, I_ADD1, 1'b0, 1'b1);
      tick;
      drive(1'b1, I_ADD7, 1'b0, 1'b1);
      tick;
      drive(1'b1, I_ADD2, 1'b0, 1'b1);
      tick;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check_fwd("c8.gap1", 2'b01, 2'b01);
      tick;

      // load-use
      drive(1'b1, I_LD, 1'b0, 1'b1);
      tick;
      drive(1'b1, I_STD, 1'b0, 1'b1);
      check_flow("c10.loaduse", 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("c10.stall", 32'(stall_cycles), 32'd0);
      tick;
      drive(1'b1, I_STD, 1'b0, 1'b1);
      check_flow("c11.after_stall", 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("c11.stall", 32'(stall_cycles), 32'd1);
      tick;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check_fwd("c12.std_ex", 2'b01, 2'b00);
      tick;

      // taken branch flush; flushed ld must not cause a load-use stall
      drive(1'b1, I_BC, 1'b0, 1'b1);
      tick;
      drive(1'b1, I_LD, 1'b1, 1'b1);
      check_flow("c14.flush", 1'b1, 1'b1, 1'b1, 1'b1);
      check_val("c14.flush_cnt", 32'(flush_count), 32'd0);
      tick;
      drive(1'b1, I_STD, 1'b0, 1'b1);
      check_flow("c15.ex_invalid", 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("c15.flush_cnt", 32'(flush_count), 32'd1);
      tick;

      // freeze with a taken branch in EX
      drive(1'b1, I_ADD1, 1'b0, 1'b1);
      tick;
      drive(1'b1, I_ADD2, 1'b0, 1'b1);
      tick;
      drive(1'b1, I_BC44, 1'b0, 1'b1);
      tick;
      drive(1'b1, I_LD, 1'b1, 1'b0);
      check_val("c19.state", 32'(ctrl_state), 32'h1);
      check_flow("c19.freeze", 1'b0, 1'b0, 1'b0, 1'b0);
      check_fwd("c19", 2'b01, 2'b01);
      check_val("c19.stall", 32'(stall_cycles), 32'd1);
      tick;
      drive(1'b1, I_LD, 1'b1, 1'b0);
      check_val("c20.state", 32'(ctrl_state), 32'h2);
      check_flow("c20.freeze", 1'b0, 1'b0, 1'b0, 1'b0);
      check_fwd("c20.held", 2'b01, 2'b01);
      tick;
      drive(1'b1, I_LD, 1'b1, 1'b0);
      check_val("c21.stall", 32'(stall_cycles), 32'd3);
      check_fwd("c21.held", 2'b01, 2'b01);
      tick;
      drive(1'b1, I_LD, 1'b1, 1'b1);
      check_val("c22.state", 32'(ctrl_state), 32'h2);
      check_flow("c22.late_flush", 1'b1, 1'b1, 1'b1, 1'b1);
      check_fwd("c22.held", 2'b01, 2'b01);
      check_val("c22.stall", 32'(stall_cycles), 32'd4);
      check_val("c22.sat_stall", 32'(stall_cycles2), 32'd3);
      tick;
      drive(1'b1, I_STD, 1'b0, 1'b1);
      check_val("c23.state", 32'(ctrl_state), 32'h1);
      check_flow("c23", 1'b1, 1'b1, 1'b0, 1'b0);
      check_fwd("c23", 2'b00, 2'b00);
      check_val("c23.flush", 32'(flush_count), 32'd2);
      check_val("c23.sat_flush", 32'(flush_count2), 32'd2);
      check_val("c23.sat_stall", 32'(stall_cycles2), 32'd3);
      tick;

      // reset during a load-use stall
      drive(1'b1, I_LD, 1'b0, 1'b1);
      tick;
      drive(1'b1, I_STD, 1'b0, 1'b1);
      check_flow("c25.loaduse", 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_val("c26.state", 32'(ctrl_state), 32'h0);
      check_flow("c26", 1'b0, 1'b0, 1'b0, 1'b1);
      check_fwd("c26", 2'b00, 2'b00);
      check_val("c26.stall", 32'(stall_cycles), 32'd0);
      check_val("c26.flush", 32'(flush_count), 32'd0);
      check_val("c26.sat_stall", 32'(stall_cycles2), 32'd0);
      check_val("c26.sat_flush", 32'(flush_count2), 32'd0);
      tick;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_val("c27.state", 32'(ctrl_state), 32'h0);
      tick;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check_val("c28.state", 32'(ctrl_state), 32'h1);
      check_val("c28.sat_state", 32'(ctrl_state2), 32'h1);
      check_val("c28.stall", 32'(stall_cycles), 32'd0);
      check_flow("c28", 1'b1, 1'b1, 1'b0, 1'b0);
      tick;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
